// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
// Shared definitions for the button debounce control stage:
//   - state_t             : 2-bit FSM state encoding
//   - DEFAULT_SYNC_STAGES : default depth of the input synchroniser
//   - reset_state()       : idle state that matches a given idle button level
// -----------------------------------------------------------------------------
package debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        WAIT_HIGH   = 2'd1,
        STABLE_HIGH = 2'd2,
        WAIT_LOW    = 2'd3
    } state_t;

    localparam int DEFAULT_SYNC_STAGES = 2;

    // The idle state must agree with the idle level so that a button resting
    // at its reset level never starts a spurious debounce interval.
    function automatic state_t reset_state(input logic level);
        return level ? STABLE_HIGH : STABLE_LOW;
    endfunction

endpackage : debounce_pkg

// File: rtl/debounce_fsm_sync_chain.sv
// -----------------------------------------------------------------------------
// sync_chain
// Multi-flop synchroniser for a single asynchronous level.
//
// Parameters:
//   STAGES      : number of flops in the chain (>= 2)
//   RESET_LEVEL : value loaded into every flop on reset
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   din  : asynchronous input level
//   dout : synchronised level, STAGES cycles behind din
// -----------------------------------------------------------------------------
module sync_chain
    import debounce_pkg::*;
#(
    parameter int   STAGES      = DEFAULT_SYNC_STAGES,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [STAGES-1:0] sync_p0;

    // Stage boundary: asynchronous input -> clock domain, shifting toward MSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= {STAGES{RESET_LEVEL}};
        end else begin
            sync_p0 <= {sync_p0[STAGES-2:0], din};
        end
    end

    assign dout = sync_p0[STAGES-1];

endmodule : sync_chain

// File: rtl/debounce_fsm.sv
// -----------------------------------------------------------------------------
// debounce_fsm
// Control stage in front of a debounce timer. The raw button is synchronised,
// then a 4-state FSM enables the timer while the synchronised level differs
// from the debounced level. The new level is committed only when the timer
// reports done and the input is still at the new level; any reversion first
// drops the timer enable, which clears the timer.
//
// Parameters:
//   SYNC_STAGES : synchroniser depth (>= 2)
//   RESET_LEVEL : idle level of the button, synchroniser and db_out
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   btn_in     : raw asynchronous button level
//   timer_done : one-cycle pulse, timer interval elapsed while enabled
//   timer_en   : timer enable (registered, decoded from state only)
//   db_out     : debounced level (registered)
//   rise_pulse : one-cycle pulse the cycle after db_out goes 0->1 (optional)
//   fall_pulse : one-cycle pulse the cycle after db_out goes 1->0 (optional)
//
// Optional feature macro: DEBOUNCE_EDGE_PULSE_EN adds rise_pulse/fall_pulse.
// -----------------------------------------------------------------------------
module debounce_fsm
    import debounce_pkg::*;
#(
    parameter int   SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    input  logic timer_done,
    output logic timer_en,
`ifdef DEBOUNCE_EDGE_PULSE_EN
    output logic db_out,
    output logic rise_pulse,
    output logic fall_pulse
`else
    output logic db_out
`endif
);

    logic   btn_s;
    state_t state;

    sync_chain #(
        .STAGES      (SYNC_STAGES),
        .RESET_LEVEL (RESET_LEVEL)
    ) u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (btn_in),
        .dout (btn_s)
    );

    // Stage boundary: synchronised level -> state / enable / debounced level.
    // timer_en is registered together with the next state, so it always equals
    // "state is a WAIT state" with no path from any input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= reset_state(RESET_LEVEL);
            timer_en <= 1'b0;
            db_out   <= RESET_LEVEL;
        end else begin
            case (state)
                STABLE_LOW: begin
                    if (btn_s) begin
                        state    <= WAIT_HIGH;
                        timer_en <= 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    // A reversion takes priority over a coincident timer_done.
                    if (!btn_s) begin
                        state    <= STABLE_LOW;
                        timer_en <= 1'b0;
                    end else if (timer_done) begin
                        state    <= STABLE_HIGH;
                        timer_en <= 1'b0;
                        db_out   <= 1'b1;
                    end
                end
                STABLE_HIGH: begin
                    if (!btn_s) begin
                        state    <= WAIT_LOW;
                        timer_en <= 1'b1;
                    end
                end
                WAIT_LOW: begin
                    if (btn_s) begin
                        state    <= STABLE_HIGH;
                        timer_en <= 1'b0;
                    end else if (timer_done) begin
                        state    <= STABLE_LOW;
                        timer_en <= 1'b0;
                        db_out   <= 1'b0;
                    end
                end
                default: begin
                    state    <= reset_state(RESET_LEVEL);
                    timer_en <= 1'b0;
                    db_out   <= RESET_LEVEL;
                end
            endcase
        end
    end

`ifdef DEBOUNCE_EDGE_PULSE_EN
    logic db_p1;

    // Stage boundary: debounced level -> edge pulses one cycle later.
    // db_out moves at most once per edge, so rise and fall are exclusive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_p1      <= RESET_LEVEL;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            db_p1      <= db_out;
            rise_pulse <= db_out & ~db_p1;
            fall_pulse <= ~db_out & db_p1;
        end
    end
`endif

endmodule : debounce_fsm

// File: tb/tb_debounce_fsm.sv
// -----------------------------------------------------------------------------
// tb_debounce_fsm
// Self-checking bench for debounce_fsm (SYNC_STAGES=2). Instance u_dut uses
// RESET_LEVEL=0; u_dut1 uses RESET_LEVEL=1. Build with +define+DEBOUNCE_EDGE_PULSE_EN
// to also check the edge pulse outputs.
// -----------------------------------------------------------------------------
module tb_debounce_fsm;

    localparam int SYNC      = 2;
    localparam int TIMER_LEN = 10;

    logic clk = 1'b0;
    logic rst, btn_in, done_drv, use_timer;
    logic timer_done, timer_en, db_out;
    logic rise_pulse, fall_pulse;

    logic rst1, btn1, done1;
    logic en1, db1;
    logic rise1, fall1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Behavioural timer: done pulses once TIMER_LEN enabled edges have elapsed.
    int   tcnt;
    logic tmr_done;
    always @(posedge clk or posedge rst) begin
        if (rst)           tcnt <= 0;
        else if (!timer_en) tcnt <= 0;
        else               tcnt <= tcnt + 1;
    end
    assign tmr_done   = timer_en && (tcnt == TIMER_LEN - 1);
    assign timer_done = use_timer ? tmr_done : done_drv;

`ifdef DEBOUNCE_EDGE_PULSE_EN
    debounce_fsm #(.SYNC_STAGES(SYNC), .RESET_LEVEL(1'b0)) u_dut (
        .clk(clk), .rst(rst), .btn_in(btn_in), .timer_done(timer_done),
        .timer_en(timer_en), .db_out(db_out),
        .rise_pulse(rise_pulse), .fall_pulse(fall_pulse));
    debounce_fsm #(.SYNC_STAGES(SYNC), .RESET_LEVEL(1'b1)) u_dut1 (
        .clk(clk), .rst(rst1), .btn_in(btn1), .timer_done(done1),
        .timer_en(en1), .db_out(db1),
        .rise_pulse(rise1), .fall_pulse(fall1));
`else
    debounce_fsm #(.SYNC_STAGES(SYNC), .RESET_LEVEL(1'b0)) u_dut (
        .clk(clk), .rst(rst), .btn_in(btn_in), .timer_done(timer_done),
        .timer_en(timer_en), .db_out(db_out));
    debounce_fsm #(.SYNC_STAGES(SYNC), .RESET_LEVEL(1'b1)) u_dut1 (
        .clk(clk), .rst(rst1), .btn_in(btn1), .timer_done(done1),
        .timer_en(en1), .db_out(db1));
    assign rise_pulse = 1'b0;
    assign fall_pulse = 1'b0;
    assign rise1      = 1'b0;
    assign fall1      = 1'b0;
`endif

    typedef struct {
        logic btn;
        logic done;
        logic en;
        logic db;
        logic rise;
        logic fall;
    } vec_t;

    vec_t tbl[15];

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        btn_in    = 1'b0;
        done_drv  = 1'b0;
        use_timer = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Drive a new held level and measure latencies to enable and commit.
    task automatic press(input logic lvl, input string tag);
        int en_at, db_at, rise_n, fall_n, rise_at, fall_at, both;
        logic en_after;
        en_at = -1; db_at = -1; rise_n = 0; fall_n = 0;
        rise_at = -1; fall_at = -1; both = 0; en_after = 1'b1;
        use_timer = 1'b1;
        btn_in    = lvl;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (timer_en && en_at < 0) en_at = i;
            if (db_out === lvl && db_at < 0) begin
                db_at    = i;
                en_after = timer_en;
            end
            if (rise_pulse) begin rise_n++; rise_at = i; end
            if (fall_pulse) begin fall_n++; fall_at = i; end
            if (rise_pulse && fall_pulse) both++;
        end
        check_int({tag, "_en_latency"}, en_at, SYNC + 1);
        check_int({tag, "_db_latency"}, db_at, SYNC + 1 + TIMER_LEN);
        check({tag, "_en_low_after_commit"}, en_after, 1'b0);
        check({tag, "_en_idle"}, timer_en, 1'b0);
`ifdef DEBOUNCE_EDGE_PULSE_EN
        check_int({tag, "_rise_count"}, rise_n, lvl ? 1 : 0);
        check_int({tag, "_fall_count"}, fall_n, lvl ? 0 : 1);
        check_int({tag, "_pulse_pos"}, lvl ? rise_at : fall_at, db_at + 1);
        check_int({tag, "_both_pulses"}, both, 0);
`endif
    endtask

    // Reference model state for the randomized run.
    logic m_hist[$];
    logic m_db, m_wait, m_rise, m_fall, m_pend_r, m_pend_f;

    initial begin
        rst1  = 1'b1;
        btn1  = 1'b1;
        done1 = 1'b0;
        do_reset();

        check("reset_en", timer_en, 1'b0);
        check("reset_db", db_out, 1'b0);
        check("reset_rise", rise_pulse, 1'b0);
        check("reset_fall", fall_pulse, 1'b0);

        // ---- Table: directly driven timer_done, SYNC=2 timing ----
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 15; i++) begin
            btn_in   = tbl[i].btn;
            done_drv = tbl[i].done;
            tick();
            check($sformatf("tbl%0d_en", i), timer_en, tbl[i].en);
            check($sformatf("tbl%0d_db", i), db_out, tbl[i].db);
`ifdef DEBOUNCE_EDGE_PULSE_EN
            check($sformatf("tbl%0d_rise", i), rise_pulse, tbl[i].rise);
            check($sformatf("tbl%0d_fall", i), fall_pulse, tbl[i].fall);
`endif
        end
        done_drv = 1'b0;

        // ---- Clean press and release with the behavioural timer ----
        press(1'b1, "press");
        press(1'b0, "release");

        // ---- Spurious timer_done in STABLE_LOW ----
        use_timer = 1'b0;
        done_drv  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("spurious%0d_en", i), timer_en, 1'b0);
            check($sformatf("spurious%0d_db", i), db_out, 1'b0);
        end
        done_drv = 1'b0;

        // ---- Bounce: high 4 cycles, low, then a full stable press ----
        begin
            logic saw_en, db_bad;
            saw_en = 1'b0; db_bad = 1'b0;
            use_timer = 1'b1;
            btn_in = 1'b1;
            for (int i = 0; i < 4; i++) begin
                tick();
                if (timer_en) saw_en = 1'b1;
                if (db_out) db_bad = 1'b1;
            end
            btn_in = 1'b0;
            for (int i = 0; i < 4; i++) begin
                tick();
                if (db_out) db_bad = 1'b1;
            end
            check("bounce_en_seen", saw_en, 1'b1);
            check("bounce_en_dropped", timer_en, 1'b0);
            check("bounce_db_held", db_bad, 1'b0);
        end
        press(1'b1, "bounce_press");
        press(1'b0, "bounce_release");

        // ---- Asynchronous reset in WAIT_HIGH ----
        begin
            int waited;
            waited = 0;
            use_timer = 1'b1;
            btn_in = 1'b1;
            while (!timer_en && waited < 10) begin
                tick();
                waited++;
            end
            check("rstwait_entered", timer_en, 1'b1);
            #2;
            rst = 1'b1;
            #1;
            check("rstwait_en", timer_en, 1'b0);
            check("rstwait_db", db_out, 1'b0);
            btn_in = 1'b0;
            tick();
            rst = 1'b0;
            tick();
        end

        // ---- Randomized run against the reference model ----
        do_reset();
        m_hist.delete();
        for (int i = 0; i < SYNC; i++) m_hist.push_front(1'b0);
        m_db = 1'b0; m_wait = 1'b0; m_rise = 1'b0; m_fall = 1'b0;
        m_pend_r = 1'b0; m_pend_f = 1'b0;
        for (int n = 0; n < 600; n++) begin
            logic s, commit, was_db;
            if ($urandom_range(0, 3) == 0) btn_in = ~btn_in;
            done_drv = ($urandom_range(0, 2) == 0);
            @(posedge clk);
            s = m_hist[SYNC-1];
            void'(m_hist.pop_back());
            m_hist.push_front(btn_in);
            was_db   = m_db;
            commit   = m_wait && (s != was_db) && done_drv;
            m_rise   = m_pend_r;
            m_fall   = m_pend_f;
            m_pend_r = commit && s;
            m_pend_f = commit && !s;
            if (commit) m_db = s;
            m_wait = (s != was_db) && !commit;
            #1;
            if (timer_en !== m_wait || db_out !== m_db) begin
                check($sformatf("rand%0d_en", n), timer_en, m_wait);
                check($sformatf("rand%0d_db", n), db_out, m_db);
            end else begin
                checks += 2;
            end
`ifdef DEBOUNCE_EDGE_PULSE_EN
            check($sformatf("rand%0d_rise", n), rise_pulse, m_rise);
            check($sformatf("rand%0d_fall", n), fall_pulse, m_fall);
`endif
        end
        done_drv = 1'b0;

        // ---- RESET_LEVEL=1 instance ----
        check("rl1_reset_db", db1, 1'b1);
        check("rl1_reset_en", en1, 1'b0);
        check("rl1_reset_rise", rise1, 1'b0);
        check("rl1_reset_fall", fall1, 1'b0);
        rst1 = 1'b0;
        begin
            logic en_seen;
            en_seen = 1'b0;
            for (int i = 0; i < 5; i++) begin
                tick();
                if (en1) en_seen = 1'b1;
            end
            check("rl1_idle_en", en_seen, 1'b0);
            check("rl1_idle_db", db1, 1'b1);
        end
        btn1 = 1'b0;
        for (int i = 0; i < SYNC + 1; i++) tick();
        check("rl1_wait_low_en", en1, 1'b1);
        check("rl1_wait_low_db", db1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_debounce_fsm
